// File: rtl/rom_tt_pkg.sv
// Shared types and CRC helper for the exhaustive truth-table sweeper.
// States, CRC-16/CCITT constants and the single-bit CRC update step.
package rom_tt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SAMPLE,
        CHECK,
        FIN
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial CCITT step: the incoming bit is XORed with the register MSB.
    function automatic logic [15:0] crc16_step(input logic [15:0] sig, input logic b);
        logic fb;
        fb = sig[15] ^ b;
        return {sig[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/rom_tt_sweeper_if.sv
// Stimulus/capture bundle between the sweeper (master) and its user (slave).
// The alpha/invariant pair only exists when AUTOSYM_CHECK_EN is defined.
interface rom_tt_sweeper_if #(
    parameter int N_IN = 7
);
    logic                 start;
    logic [N_IN-1:0]      x_out;
    logic                 y_in;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   tt_out;
    logic [15:0]          sig_out;
    logic [N_IN:0]        ones_cnt;
`ifdef AUTOSYM_CHECK_EN
    logic [N_IN-1:0]      alpha;
    logic                 invariant;

    modport master (
        input  start, y_in, alpha,
        output x_out, busy, done, tt_out, sig_out, ones_cnt, invariant
    );
    modport slave (
        output start, y_in, alpha,
        input  x_out, busy, done, tt_out, sig_out, ones_cnt, invariant
    );
`else
    modport master (
        input  start, y_in,
        output x_out, busy, done, tt_out, sig_out, ones_cnt
    );
    modport slave (
        output start, y_in,
        input  x_out, busy, done, tt_out, sig_out, ones_cnt
    );
`endif
endinterface

// File: rtl/rom_tt_sweeper_crc16.sv
// Serial CRC-16/CCITT register: clear loads the init value, enable shifts one bit in.
module rom_tt_crc16
    import rom_tt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_sig
);
    logic [15:0] r_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sig <= 16'h0000;
        end else if (i_clr) begin
            r_sig <= CRC_INIT;
        end else if (i_en) begin
            r_sig <= crc16_step(r_sig, i_bit);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/rom_tt_sweeper.sv
// Exhaustive sweeper: drives every input vector, captures y0 into a truth table,
// CRC signature and on-set count. Optional symmetry check under AUTOSYM_CHECK_EN.
module rom_tt_sweeper
    import rom_tt_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    rom_tt_sweeper_if.master bus
);
    localparam int            N_VEC   = 2 ** N_IN;
    localparam int            SW      = $clog2(SETTLE + 2);
    localparam logic [N_IN:0] V_LAST  = (N_IN + 1)'(N_VEC - 1);
    localparam logic [SW-1:0] S_LAST  = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    // With no settle time APPLY collapses into SAMPLE: one cycle per vector.
    localparam state_t        ST_VEC  = (SETTLE == 0) ? SAMPLE : APPLY;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_IN:0]    r_v;
    logic [SW-1:0]    r_settle;
    logic [N_VEC-1:0] r_tt;
    logic [N_IN:0]    r_ones;
    logic [15:0]      w_sig;

    logic w_accept;
    logic w_settling;
    logic w_sample;
    logic w_busy;
    logic w_done;

`ifdef AUTOSYM_CHECK_EN
    logic [N_IN:0]   r_c;
    logic [N_IN-1:0] r_alpha;
    logic            r_mis;
    logic            r_inv;
    logic            w_checking;
    logic            w_pair_mis;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = ST_VEC;
                end
            end
            APPLY: begin
                if (r_settle == S_LAST) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (r_v == V_LAST) begin
`ifdef AUTOSYM_CHECK_EN
                    w_state_next = CHECK;
`else
                    w_state_next = FIN;
`endif
                end else begin
                    w_state_next = ST_VEC;
                end
            end
`ifdef AUTOSYM_CHECK_EN
            CHECK: begin
                if (r_c == V_LAST) begin
                    w_state_next = FIN;
                end
            end
`endif
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept   = (r_state == IDLE) && bus.start;
        w_settling = (r_state == APPLY);
        w_sample   = (r_state == SAMPLE);
        w_done     = (r_state == FIN);
        w_busy     = (r_state == APPLY) || (r_state == SAMPLE) || (r_state == CHECK);
`ifdef AUTOSYM_CHECK_EN
        w_checking = (r_state == CHECK);
`endif
    end

`ifdef AUTOSYM_CHECK_EN
    assign w_pair_mis = r_tt[r_c[N_IN-1:0]] ^ r_tt[r_c[N_IN-1:0] ^ r_alpha];
`endif

    // Vector counter, truth table and on-set count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v      <= '0;
            r_settle <= '0;
            r_tt     <= '0;
            r_ones   <= '0;
`ifdef AUTOSYM_CHECK_EN
            r_c      <= '0;
            r_alpha  <= '0;
            r_mis    <= 1'b0;
            r_inv    <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_v      <= '0;
                r_settle <= '0;
                r_tt     <= '0;
                r_ones   <= '0;
`ifdef AUTOSYM_CHECK_EN
                r_c      <= '0;
                r_alpha  <= bus.alpha;
                r_mis    <= 1'b0;
                r_inv    <= 1'b0;
`endif
            end
            if (w_settling) begin
                r_settle <= r_settle + SW'(1);
            end
            if (w_sample) begin
                r_settle               <= '0;
                r_tt[r_v[N_IN-1:0]]    <= bus.y_in;
                r_ones                 <= r_ones + (N_IN + 1)'(bus.y_in);
                // The last vector stays on x_out through FIN and IDLE.
                if (r_v != V_LAST) begin
                    r_v <= r_v + (N_IN + 1)'(1);
                end
            end
`ifdef AUTOSYM_CHECK_EN
            if (w_checking) begin
                if (w_pair_mis) begin
                    r_mis <= 1'b1;
                end
                if (r_c == V_LAST) begin
                    r_inv <= ~(r_mis | w_pair_mis);
                end else begin
                    r_c <= r_c + (N_IN + 1)'(1);
                end
            end
`endif
        end
    end

    rom_tt_crc16 u_crc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_accept),
        .i_en  (w_sample),
        .i_bit (bus.y_in),
        .o_sig (w_sig)
    );

    assign bus.x_out    = r_v[N_IN-1:0];
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.tt_out   = r_tt;
    assign bus.sig_out  = w_sig;
    assign bus.ones_cnt = r_ones;
`ifdef AUTOSYM_CHECK_EN
    assign bus.invariant = r_inv;
`endif

endmodule

// File: tb/tb_rom_tt_sweeper.sv
// Self-checking bench for rom_tt_sweeper: scoreboard of model results popped on done,
// plus scenario tasks. Exercises AUTOSYM_CHECK_EN when that macro is defined.
module tb_rom_tt_sweeper;

    typedef struct {
        logic [127:0] tt;
        logic [15:0]  sig;
        logic [7:0]   ones;
        int           cycles;
        logic         inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mode0    = 0;
    int mode2    = 0;

    exp_t sb0[$];
    exp_t sb2[$];

    logic [127:0] ref_tt;
    logic [15:0]  ref_sig;
    logic [7:0]   ref_ones;
    logic [6:0]   r_d1;
    logic [6:0]   r_d2;

    rom_tt_sweeper_if #(.N_IN(7)) bus0 ();
    rom_tt_sweeper_if #(.N_IN(7)) bus2 ();

    rom_tt_sweeper #(.N_IN(7), .SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    rom_tt_sweeper #(.N_IN(7), .SETTLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Functions under test; modes 3 and 4 are an original/optimized PLA pair.
    function automatic logic fmodel(input int mode, input logic [6:0] v);
        case (mode)
            1: return v[0];
            2: return v[6];
            3: return (v[0] & v[1]) | (v[0] & ~v[1] & v[2]) | (v[3] & v[4] & v[5])
                    | (v[3] & v[4] & ~v[5]) | (v[0] & v[1] & v[6]);
            4: return (v[0] & (v[1] | v[2])) | (v[3] & v[4]);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sw_crc(input logic [127:0] tt);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 128; i++) begin
            fb = c[15] ^ tt[i];
            c  = c << 1;
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // DUT0 sees the function combinationally; DUT2 sees it through a 2-cycle lag
    // so a sweeper that samples before its settle time captures stale values.
    always_comb bus0.y_in = fmodel(mode0, bus0.x_out);
    always @(posedge clk) begin
        r_d1 <= bus2.x_out;
        r_d2 <= r_d1;
    end
    always_comb bus2.y_in = fmodel(mode2, r_d2);

    task automatic push_exp(input int idx, input int mode, input int settle, input logic [6:0] alpha);
        exp_t e;
        e.tt = '0;
        for (int v = 0; v < 128; v++) e.tt[v] = fmodel(mode, 7'(v));
        e.sig  = sw_crc(e.tt);
        e.ones = 8'($countones(e.tt));
        e.cycles = 128 * (settle + 1);
        e.inv = 1'b1;
        for (int v = 0; v < 128; v++) begin
            if (e.tt[v] != e.tt[7'(v) ^ alpha]) e.inv = 1'b0;
        end
`ifdef AUTOSYM_CHECK_EN
        e.cycles = e.cycles + 128;
`endif
        if (idx == 0) sb0.push_back(e);
        else sb2.push_back(e);
    endtask

    // Scoreboard monitor for DUT0
    initial begin : mon0
        exp_t e;
        int   cyc;
        int   t0;
        logic bprev;
        cyc = 0; t0 = 0; bprev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus0.busy && !bprev) t0 = cyc;
            bprev = bus0.busy;
            if (bus0.done) begin
                checks++;
                if (sb0.size() == 0) begin
                    failures++;
                    $display("FAIL dut0_unexpected_done: done=1 with no expected result queued");
                end else begin
                    e = sb0.pop_front();
                    if (bus0.tt_out !== e.tt) begin
                        failures++;
                        $display("FAIL dut0_tt: got %h expected %h", bus0.tt_out, e.tt);
                    end
                    checks++;
                    if (bus0.sig_out !== e.sig) begin
                        failures++;
                        $display("FAIL dut0_sig: got %h expected %h", bus0.sig_out, e.sig);
                    end
                    checks++;
                    if (bus0.ones_cnt !== e.ones) begin
                        failures++;
                        $display("FAIL dut0_ones: got %0d expected %0d", bus0.ones_cnt, e.ones);
                    end
                    checks++;
                    if (cyc - t0 != e.cycles) begin
                        failures++;
                        $display("FAIL dut0_cycles: got %0d expected %0d", cyc - t0, e.cycles);
                    end
`ifdef AUTOSYM_CHECK_EN
                    checks++;
                    if (bus0.invariant !== e.inv) begin
                        failures++;
                        $display("FAIL dut0_invariant: got %b expected %b", bus0.invariant, e.inv);
                    end
`endif
                    $display("dut0 sweep done: tt=%h sig=%h ones=%0d cycles=%0d", bus0.tt_out, bus0.sig_out, bus0.ones_cnt, cyc - t0);
                end
            end
        end
    end

    // Scoreboard monitor for DUT2, including per-vector hold length
    initial begin : mon2
        exp_t       e;
        int         cyc;
        int         t0;
        int         run;
        int         bad;
        int         nruns;
        logic [6:0] lastx;
        logic       bprev;
        cyc = 0; t0 = 0; run = 0; bad = 0; nruns = 0; lastx = '0; bprev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus2.busy && !bprev) begin
                t0 = cyc; run = 1; bad = 0; nruns = 0; lastx = bus2.x_out;
            end else if (bus2.busy) begin
                if (bus2.x_out === lastx) run++;
                else begin
                    if (run != 3) bad++;
                    nruns++;
                    run = 1;
                    lastx = bus2.x_out;
                end
            end
            bprev = bus2.busy;
            if (bus2.done) begin
                if (run != 3) bad++;
                nruns++;
                checks++;
                if (bad != 0 || nruns != 128) begin
                    failures++;
                    $display("FAIL dut2_x_stable: bad_runs=%0d runs=%0d required bad_runs=0 runs=128", bad, nruns);
                end
                checks++;
                if (sb2.size() == 0) begin
                    failures++;
                    $display("FAIL dut2_unexpected_done: done=1 with no expected result queued");
                end else begin
                    e = sb2.pop_front();
                    if (bus2.tt_out !== e.tt) begin
                        failures++;
                        $display("FAIL dut2_tt: got %h expected %h", bus2.tt_out, e.tt);
                    end
                    checks++;
                    if (bus2.sig_out !== e.sig) begin
                        failures++;
                        $display("FAIL dut2_sig: got %h expected %h", bus2.sig_out, e.sig);
                    end
                    checks++;
                    if (bus2.ones_cnt !== e.ones) begin
                        failures++;
                        $display("FAIL dut2_ones: got %0d expected %0d", bus2.ones_cnt, e.ones);
                    end
                    checks++;
                    if (cyc - t0 != e.cycles) begin
                        failures++;
                        $display("FAIL dut2_cycles: got %0d expected %0d", cyc - t0, e.cycles);
                    end
                    $display("dut2 sweep done: tt=%h sig=%h ones=%0d cycles=%0d", bus2.tt_out, bus2.sig_out, bus2.ones_cnt, cyc - t0);
                end
            end
        end
    end

    task automatic pulse_start(input int idx);
        @(negedge clk);
        if (idx == 0) bus0.start = 1'b1; else bus2.start = 1'b1;
        @(negedge clk);
        if (idx == 0) bus0.start = 1'b0; else bus2.start = 1'b0;
    endtask

    task automatic wait_done(input int idx);
        int n;
        n = 0;
        while (((idx == 0) ? bus0.done : bus2.done) !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            failures++;
            $display("FAIL wait_done_dut%0d: done not seen within %0d cycles", idx, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.x_out !== 7'd0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl0: x=%h busy=%b done=%b required 0 0 0", bus0.x_out, bus0.busy, bus0.done);
        end
        checks++;
        if (bus0.tt_out !== 128'd0 || bus0.sig_out !== 16'd0 || bus0.ones_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_data0: tt=%h sig=%h ones=%0d required all 0", bus0.tt_out, bus0.sig_out, bus0.ones_cnt);
        end
        checks++;
        if (bus2.x_out !== 7'd0 || bus2.busy !== 1'b0 || bus2.tt_out !== 128'd0 || bus2.sig_out !== 16'd0) begin
            failures++;
            $display("FAIL reset_dut2: x=%h busy=%b tt=%h sig=%h required all 0", bus2.x_out, bus2.busy, bus2.tt_out, bus2.sig_out);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset checked");
    endtask

    task automatic test_zero();
        mode0 = 0;
        push_exp(0, 0, 0, 7'd0);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_busy_at_done: got %b required 0", bus0.busy);
        end
    endtask

    task automatic test_loopback();
        mode0 = 1;
        push_exp(0, 1, 0, 7'd0);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.tt_out !== {64{2'b10}} || bus0.ones_cnt !== 8'd64) begin
            failures++;
            $display("FAIL loopback_const: tt=%h ones=%0d required aaaa..aaaa 64", bus0.tt_out, bus0.ones_cnt);
        end
        ref_tt = bus0.tt_out;
        ref_sig = bus0.sig_out;
        repeat (3) @(negedge clk);
        checks++;
        if (bus0.x_out !== 7'd127 || bus0.tt_out !== ref_tt || bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_after_done: x=%h busy=%b tt=%h required x=7f busy=0 results held", bus0.x_out, bus0.busy, bus0.tt_out);
        end
    endtask

    task automatic test_settle();
        mode2 = 2;
        push_exp(2, 2, 2, 7'd0);
        pulse_start(2);
        wait_done(2);
        checks++;
        if (bus2.tt_out !== {{64{1'b1}}, {64{1'b0}}} || bus2.ones_cnt !== 8'd64) begin
            failures++;
            $display("FAIL settle_const: tt=%h ones=%0d required upper ones lower zeros 64", bus2.tt_out, bus2.ones_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        mode0 = 1;
        push_exp(0, 1, 0, 7'd0);
        pulse_start(0);
        n = 0;
        while (bus0.done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            bus0.start = (n == 20 || n == 70) ? 1'b1 : 1'b0;
        end
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        checks++;
        if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            failures++;
            $display("FAIL start_with_done: busy=%b done=%b required 0 0", bus0.busy, bus0.done);
        end
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0 || bus0.x_out !== 7'd127) begin
            failures++;
            $display("FAIL start_with_done_idle: busy=%b x=%h required 0 7f", bus0.busy, bus0.x_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mode0 = 1;
        pulse_start(0);
        n = 0;
        while (bus0.x_out !== 7'd50 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        bus0.start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus0.x_out !== 7'd0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0 || bus0.tt_out !== 128'd0
            || bus0.sig_out !== 16'd0 || bus0.ones_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: x=%h busy=%b done=%b tt=%h sig=%h ones=%0d required all 0",
                     bus0.x_out, bus0.busy, bus0.done, bus0.tt_out, bus0.sig_out, bus0.ones_cnt);
        end
        rst = 1'b0;
        bus0.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus0.busy !== 1'b0) begin
            failures++;
            $display("FAIL start_during_reset: busy=%b required 0", bus0.busy);
        end
        push_exp(0, 1, 0, 7'd0);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.tt_out !== ref_tt || bus0.sig_out !== ref_sig) begin
            failures++;
            $display("FAIL rerun_after_reset: tt=%h sig=%h required %h %h", bus0.tt_out, bus0.sig_out, ref_tt, ref_sig);
        end
    endtask

    task automatic test_golden();
        mode0 = 3;
        push_exp(0, 3, 0, 7'd0);
        pulse_start(0);
        wait_done(0);
        ref_tt = bus0.tt_out;
        ref_sig = bus0.sig_out;
        ref_ones = bus0.ones_cnt;
        mode0 = 4;
        push_exp(0, 4, 0, 7'd0);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.tt_out !== ref_tt || bus0.sig_out !== ref_sig || bus0.ones_cnt !== ref_ones) begin
            failures++;
            $display("FAIL golden_pair: opt tt=%h sig=%h ones=%0d orig tt=%h sig=%h ones=%0d",
                     bus0.tt_out, bus0.sig_out, bus0.ones_cnt, ref_tt, ref_sig, ref_ones);
        end
    endtask

`ifdef AUTOSYM_CHECK_EN
    task automatic test_autosym();
        mode0 = 1;
        bus0.alpha = 7'b0000010;
        push_exp(0, 1, 0, 7'b0000010);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.invariant !== 1'b1) begin
            failures++;
            $display("FAIL autosym_alpha2: got %b required 1", bus0.invariant);
        end
        bus0.alpha = 7'b0000001;
        push_exp(0, 1, 0, 7'b0000001);
        pulse_start(0);
        wait_done(0);
        checks++;
        if (bus0.invariant !== 1'b0) begin
            failures++;
            $display("FAIL autosym_alpha1: got %b required 0", bus0.invariant);
        end
        bus0.alpha = 7'd0;
    endtask
`endif

    initial begin
        bus0.start = 1'b0;
        bus2.start = 1'b0;
`ifdef AUTOSYM_CHECK_EN
        bus0.alpha = 7'd0;
        bus2.alpha = 7'd0;
`endif
        test_reset();
        test_zero();
        test_loopback();
        test_settle();
        test_start_ignored();
        test_reset_mid();
        test_golden();
`ifdef AUTOSYM_CHECK_EN
        test_autosym();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb0.size() != 0 || sb2.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending dut0=%0d dut2=%0d required 0 0", sb0.size(), sb2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_tt_sweeper.md
Name: rom_tt_sweeper

Overview:
- Exhaustive stimulus/capture harness around a single-output combinational PLA/ROM netlist (7 inputs x0..x6, output y0).
- Upstream side: drives all 2^N_IN input vectors in ascending order.
- Downstream side: samples y0 per vector and builds the full truth table, a CRC-16 signature and an on-set count.
- Used on-chip/in-sim to confirm that optimized netlists equal their original PLA functions.

Parameters:
- N_IN, 7, number of function inputs; vector bit i drives xi.
- SETTLE, 0, extra cycles held per vector before y_in is sampled (0 = purely combinational DUT).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- x_out  out  N_IN  current input vector to the DUT; bit i -> xi.
- y_in  in  1  DUT output y0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- tt_out  out  2**N_IN  captured truth table; bit v = f(v).
- sig_out  out  16  CRC-16 signature of the truth table.
- ones_cnt  out  N_IN+1  number of vectors with f = 1.

Behaviour:
- Reset values: all outputs 0, x_out = 0, FSM = IDLE. Reset mid-sweep aborts immediately; partial results are discarded.
- FSM states: IDLE -> APPLY -> SAMPLE -> (CHECK) -> FIN -> IDLE.
- IDLE:
  - start=1 clears tt_out, ones_cnt and error state; loads sig to 0xFFFF, vector counter v to 0 and settle counter to 0.
  - Next state: APPLY, busy=1.
- APPLY:
  - x_out = v, held stable.
  - Stays SETTLE cycles, then goes to SAMPLE. With SETTLE=0, APPLY and SAMPLE merge: one cycle per vector.
- SAMPLE (x_out still = v):
  - At the clock edge, y_in is written into tt_out[v]; ones_cnt += y_in; CRC is updated.
  - CRC is CCITT: poly 0x1021, y_in is the next serial bit, bits fed in ascending v order.
  - If v = 2**N_IN-1, go to CHECK (feature on) or FIN. Otherwise v += 1 and go to APPLY.
- Per-vector cost: SETTLE+1 cycles. Sweep length: 2**N_IN*(SETTLE+1) cycles.
- FIN:
  - One cycle: done=1, busy=0.
  - Next cycle: IDLE, with results held until the next accepted start.
- x_out holds its last vector in FIN and IDLE; it returns to 0 only on reset or a new start.
- start asserted in any non-IDLE state: ignored, no queueing.
- start asserted in the same cycle as done: ignored; start is accepted only in IDLE.
- ones_cnt cannot overflow: maximum 2**N_IN fits N_IN+1 bits.
- Counter v is N_IN+1 bits wide internally, so the terminal compare never wraps.

Optional Feature:
- Macro: AUTOSYM_CHECK_EN.
- When defined:
  - Extra input alpha[N_IN-1:0], sampled on the accepted start.
  - Extra output invariant (1 bit), reset value 0.
  - After the last SAMPLE, a CHECK state scans v = 0..2**N_IN-1 at one vector per cycle and compares tt[v] with tt[v ^ alpha].
  - invariant = 1 iff no mismatch is found; it is valid with done.
  - Adds 2**N_IN cycles to the sweep.
  - alpha = 0 always yields invariant = 1.
- When undefined: no CHECK state, no alpha/invariant ports, timing exactly as in Behaviour.

Decomposition:
- Package rom_tt_pkg:
  - State enum (IDLE, APPLY, SAMPLE, CHECK, FIN).
  - CRC_POLY = 16'h1021, CRC_INIT = 16'hFFFF.
  - Function crc16_step(sig, bit).
- One sub-module: rom_tt_crc16, a serial CRC register with clear, enable and bit input.
- FSM, counters and truth-table register stay in the top.

Test Plan:
- y_in tied 0, SETTLE=0, start pulse -> done exactly 128 cycles after busy rises; tt_out = 0, ones_cnt = 0; sig_out equals the software CRC of 128 zeros.
- y_in = x_out[0] loopback -> tt_out = 128'hAAAA...AAAA, ones_cnt = 64.
- y_in = x_out[6], SETTLE=2 -> 384-cycle sweep; tt_out upper 64 bits ones, lower 64 bits zero; ones_cnt = 64; x_out stable 3 cycles per vector.
- rst asserted at vector 50, then start -> all outputs 0 right after reset; the fresh sweep is identical to an uninterrupted run; start pulses during busy have no effect.
- AUTOSYM_CHECK_EN, y_in = x_out[0]:
  - alpha = 7'b0000010 -> invariant = 1.
  - alpha = 7'b0000001 -> invariant = 0.
  - Sweep length 256 cycles.
- Golden netlist pair: original and optimized PLA each swept -> identical tt_out, sig_out and ones_cnt.
